apb_master: RTL and testbench

- APB requester that drives the same sel/enable/w_en/add/data/ready bus our APB_slave responds on.
- Takes one-at-a-time read/write commands from a local controller and runs the APB SETUP->ACCESS sequence.
- Waits on ready, captures read data and reports completion. Reports a timeout error if ready never comes.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 145 ++++++++++++++
 tb/tb_apb_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and default bus widths
// common to the APB requester and the APB_slave it talks to.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time, runs SETUP->ACCESS on the bus,
// waits for ready (with optional timeout) and reports completion via done/err.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_w_en,
    input  logic [ADDR_W-1:0] req_add,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic              sel,
    output logic              enable,
    output logic              w_en,
    output logic [ADDR_W-1:0] add,
    output logic [DATA_W-1:0] wdata,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata
);

    // A one-bit counter is kept even when the timeout is disabled so widths stay legal.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    apb_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                enable_q, enable_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   add_q, add_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                accept;
    logic                timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_en_d    = w_en_q;
        add_d     = add_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = req;
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (ready) begin
                    // ready wins over a timeout landing on the same edge
                    done_d = 1'b1;
                    if (!w_en_q) begin
                        rd_data_d = rdata;
                    end
                    if (req) begin
                        accept = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (timeout_hit) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d = StSetup;
            cnt_d   = '0;
            w_en_d  = req_w_en;
            add_d   = req_add;
            wdata_d = req_data;
        end

        sel_d    = (state_d != StIdle);
        enable_d = (state_d == StAccess);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            enable_q  <= 1'b0;
            w_en_q    <= 1'b0;
            add_q     <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            enable_q  <= enable_d;
            w_en_q    <= w_en_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign req_ack = accept & ~rst;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;
    assign rd_data = rd_data_q;
    assign sel     = sel_q;
    assign enable  = enable_q;
    assign w_en    = w_en_q;
    assign add     = add_q;
    assign wdata   = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_apb_master;

    localparam int TO = 16;

    logic       clk;
    logic       rst;
    logic       req;
    logic       req_w_en;
    logic [7:0] req_add;
    logic [7:0] req_data;
    logic       req_ack;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rd_data;
    logic       sel;
    logic       enable;
    logic       w_en;
    logic [7:0] add;
    logic [7:0] wdata;
    logic       ready;
    logic [7:0] rdata;

    apb_master #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_w_en(req_w_en),
        .req_add (req_add),
        .req_data(req_data),
        .req_ack (req_ack),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_data (rd_data),
        .sel     (sel),
        .enable  (enable),
        .w_en    (w_en),
        .add     (add),
        .wdata   (wdata),
        .ready   (ready),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: current transfer and its age on the bus (0 = setup cycle).
    bit       m_known  = 0;
    bit       m_active = 0;
    int       m_age    = 0;
    int       m_wait   = 0;
    bit       m_w      = 0;
    bit [7:0] m_add    = 0;
    bit [7:0] m_data   = 0;
    bit       m_done   = 0;
    bit       m_err    = 0;
    bit [7:0] m_rd     = 0;

    bit last_ack_exp;
    bit last_ack_dut;
    int en_cnt;
    int done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        bit exp_ack;
        #1;
        exp_ack = !rst && req && (!m_active || (m_age >= 1 && ready));
        if (m_known || rst) check("req_ack", req_ack, exp_ack);
        if (m_known) check("busy", busy, m_active);
        last_ack_exp = exp_ack;
        last_ack_dut = req_ack;
        @(posedge clk);
        #1;
        if (rst) begin
            m_known = 1; m_active = 0; m_age = 0; m_wait = 0;
            m_w = 0; m_add = 0; m_data = 0; m_done = 0; m_err = 0; m_rd = 0;
        end else if (m_known) begin
            m_done = 0;
            m_err  = 0;
            if (m_active && m_age >= 1) begin
                if (ready) begin
                    m_done = 1;
                    if (!m_w) m_rd = rdata;
                    m_active = 0;
                end else begin
                    m_wait++;
                    if (TO != 0 && m_wait >= TO) begin
                        m_done = 1; m_err = 1; m_active = 0;
                    end else begin
                        m_age++;
                    end
                end
            end else if (m_active) begin
                m_age = 1;
            end
            if (exp_ack) begin
                m_active = 1; m_age = 0; m_wait = 0;
                m_w = req_w_en; m_add = req_add; m_data = req_data;
            end
        end
        if (m_known) begin
            check("sel", sel, m_active);
            check("enable", enable, m_active && m_age >= 1);
            check("w_en", w_en, m_w);
            check("add", add, m_add);
            check("wdata", wdata, m_data);
            check("done", done, m_done);
            check("err", err, m_err);
            check("rd_data", rd_data, m_rd);
        end
        if (enable === 1'b1) en_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic set_cmd(input bit w, input bit [7:0] a, input bit [7:0] d);
        req = 1; req_w_en = w; req_add = a; req_data = d;
    endtask

    // Slave answers after 'waits' low-ready ACCESS cycles; waits < 0 never answers.
    task automatic drain(input int waits, input int budget);
        for (int i = 0; i < budget; i++) begin
            ready = m_active && m_age >= 1 && waits >= 0 && m_wait >= waits;
            step();
            if (m_done && !m_active) return;
        end
        check("drain_budget", 0, 1);
    endtask

    initial begin
        bit pending;
        bit stuck;
        rst = 1; req = 0; req_w_en = 0; req_add = 0; req_data = 0;
        ready = 0; rdata = 0;

        // Reset held with a pending command
        set_cmd(1, 8'hAB, 8'hCD);
        repeat (10) step();
        check("rst_sel", sel, 0);
        check("rst_enable", enable, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_req_ack", last_ack_dut, 0);
        rst = 0; req = 0;
        repeat (3) step();
        check("post_rst_idle", busy, 0);

        // Write, no wait states
        ready = 1;
        set_cmd(1, 8'hCD, 8'hEE);
        step();
        check("wr_sel_k", sel, 1);
        check("wr_en_k", enable, 0);
        req = 0;
        step();
        check("wr_en_k1", enable, 1);
        check("wr_w_en", w_en, 1);
        check("wr_add", add, 8'hCD);
        check("wr_wdata", wdata, 8'hEE);
        step();
        check("wr_done", done, 1);
        check("wr_err", err, 0);
        check("wr_sel_k2", sel, 0);

        // Read with 3 wait states
        ready = 0;
        set_cmd(0, 8'h33, 8'h00);
        step();
        req = 0; en_cnt = 0; done_cnt = 0; rdata = 8'h5A;
        drain(3, 20);
        step();
        check("rd3_en_cycles", en_cnt, 4);
        check("rd3_done_pulses", done_cnt, 1);
        check("rd3_rd_data", rd_data, 8'h5A);

        // Back-to-back write then read
        ready = 1; rdata = 8'h5A;
        set_cmd(1, 8'h10, 8'h11);
        step();
        req = 0; done_cnt = 0;
        step();
        set_cmd(0, 8'h20, 8'h00);
        step();
        check("b2b_ack", last_ack_dut, 1);
        check("b2b_sel", sel, 1);
        check("b2b_en_low", enable, 0);
        check("b2b_add", add, 8'h20);
        check("b2b_done1", done, 1);
        req = 0;
        step();
        check("b2b_en_high", enable, 1);
        step();
        check("b2b_done2", done, 1);
        check("b2b_pulses", done_cnt, 2);

        // Timeout on a read
        ready = 0;
        set_cmd(0, 8'h44, 8'h00);
        step();
        req = 0; en_cnt = 0; rdata = 8'hA5;
        drain(-1, 40);
        check("to_en_cycles", en_cnt, 16);
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_rd_keep", rd_data, 8'h5A);
        check("to_sel", sel, 0);

        // Reset in the middle of ACCESS
        set_cmd(1, 8'h66, 8'h77);
        step();
        req = 0;
        step();
        check("mid_en", enable, 1);
        rst = 1;
        step();
        rst = 0;
        check("mid_sel", sel, 0);
        check("mid_enable", enable, 0);
        check("mid_done", done, 0);
        check("mid_busy", busy, 0);
        set_cmd(1, 8'h01, 8'h02);
        step();
        req = 0;
        drain(0, 10);
        check("mid_wr_done", done, 1);
        check("mid_wr_err", err, 0);
        check("mid_wr_add", add, 8'h01);
        check("mid_wr_wdata", wdata, 8'h02);

        // Random traffic
        pending = 0;
        stuck = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!pending && $urandom_range(0, 2) != 0) begin
                pending  = 1;
                req_w_en = 1'($urandom);
                req_add  = 8'($urandom);
                req_data = 8'($urandom);
            end
            req   = pending;
            ready = stuck ? 1'b0 : ($urandom_range(0, 2) != 0);
            rdata = 8'($urandom);
            step();
            if (last_ack_exp) begin
                pending = 0;
                stuck   = ($urandom_range(0, 9) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
